sram_arbiter: RTL and testbench

Shares the single external 16-bit SRAM between several effect clients, such as the looper and the delay line, on one clock. Each client raises a request with an address, a write-enable and write data, and holds it until acknowledged. The arbiter grants one transaction at a time in round-robin order, drives the SRAM pins, and returns read data with a one-cycle acknowledge. It sits between the effect modules and the top-level SRAM pins and replaces per-effect direct pin drive.

---
 rtl/sram_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 34 +++
 rtl/sram_arbiter.sv | 118 +++++++++++
 tb/tb_sram_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM arbiter and its clients.
//   - FSM state encoding for the arbiter
//   - SRAM bus widths
//   - client index width (up to 4 clients)
//   - common memory-map bounds so every effect client agrees on the layout
package sram_arb_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;
    localparam int IDX_W   = 2;

    localparam logic [SRAM_AW-1:0] START_ADDR = 20'd32000;
    localparam logic [SRAM_AW-1:0] MAX_ADDR   = 20'd351999;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD0,
        S_RD1,
        S_DONE
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder.
//   req_i  : request vector, one bit per client
//   ptr_i  : client index with highest priority this round
//   any_o  : at least one request is pending
//   idx_o  : winning client, first set bit at or after ptr_i (wrapping)
module rr_pick
    import sram_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             any_o,
    output logic [IDX_W-1:0] idx_o
);

    int j;

    // Scan from the farthest offset down to offset 0 so the closest
    // requester to ptr_i is the last (and therefore winning) assignment.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        j     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            j = (int'(ptr_i) + i) % N;
            if (req_i[j]) begin
                any_o = 1'b1;
                idx_o = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one external 16-bit SRAM between effect clients.
//   i_clk, i_rst_n         : clock, async active-low reset
//   i_req/i_we_n           : per-client request level and write enable (0 = write)
//   i_addr/i_wdata         : per-client packed address (20b) and write data (16b)
//   o_ack                  : one-hot, one-cycle completion pulse
//   o_rdata                : last read data, valid with the reading client's ack
//   o_busy                 : arbiter not in S_IDLE
//   o_sram_addr/_we_n/_wdata, i_sram_rdata : SRAM pins
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [NUM_REQ-1:0]         i_we_n,
    input  logic [NUM_REQ*SRAM_AW-1:0] i_addr,
    input  logic [NUM_REQ*SRAM_DW-1:0] i_wdata,
    output logic [NUM_REQ-1:0]         o_ack,
    output logic [SRAM_DW-1:0]         o_rdata,
    output logic                       o_busy,
    output logic [SRAM_AW-1:0]         o_sram_addr,
    output logic                       o_sram_we_n,
    output logic [SRAM_DW-1:0]         o_sram_wdata,
    input  logic [SRAM_DW-1:0]         i_sram_rdata
);

    state_t               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic [SRAM_DW-1:0]   rdata_q;
    logic [SRAM_AW-1:0]   sram_addr_q;
    logic                 sram_we_n_q;
    logic [SRAM_DW-1:0]   sram_wdata_q;

    logic                 pick_any;
    logic [IDX_W-1:0]     pick_idx;
    logic [SRAM_AW-1:0]   sel_addr;
    logic [SRAM_DW-1:0]   sel_wdata;
    logic                 sel_we_n;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i (i_req),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    assign sel_addr  = i_addr[int'(pick_idx)*SRAM_AW +: SRAM_AW];
    assign sel_wdata = i_wdata[int'(pick_idx)*SRAM_DW +: SRAM_DW];
    assign sel_we_n  = i_we_n[pick_idx];

    // The SRAM pin registers double as the transaction latch: they are
    // loaded once in S_IDLE and only cleared when the transaction ends,
    // so client inputs changing afterwards cannot reach the bus.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            ptr_q        <= '0;
            ack_q        <= '0;
            rdata_q      <= '0;
            sram_addr_q  <= '0;
            sram_we_n_q  <= 1'b1;
            sram_wdata_q <= '0;
        end else begin
            ack_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (pick_any) begin
                        idx_q       <= pick_idx;
                        sram_addr_q <= sel_addr;
                        if (!sel_we_n) begin
                            state_q      <= S_WRITE;
                            sram_we_n_q  <= 1'b0;
                            sram_wdata_q <= sel_wdata;
                        end else begin
                            state_q <= S_RD0;
                        end
                    end
                end
                S_WRITE: begin
                    state_q      <= S_DONE;
                    sram_addr_q  <= '0;
                    sram_we_n_q  <= 1'b1;
                    sram_wdata_q <= '0;
                    ack_q        <= NUM_REQ'(1) << idx_q;
                end
                S_RD0: begin
                    state_q <= S_RD1;
                end
                S_RD1: begin
                    state_q     <= S_DONE;
                    rdata_q     <= i_sram_rdata;
                    sram_addr_q <= '0;
                    ack_q       <= NUM_REQ'(1) << idx_q;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ptr_q   <= (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign o_ack        = ack_q;
    assign o_rdata      = rdata_q;
    assign o_busy       = (state_q != S_IDLE);
    assign o_sram_addr  = sram_addr_q;
    assign o_sram_we_n  = sram_we_n_q;
    assign o_sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
module tb_sram_arbiter;

    logic        i_clk;
    logic        i_rst_n;
    logic [1:0]  i_req;
    logic [1:0]  i_we_n;
    logic [39:0] i_addr;
    logic [31:0] i_wdata;
    logic [1:0]  o_ack;
    logic [15:0] o_rdata;
    logic        o_busy;
    logic [19:0] o_sram_addr;
    logic        o_sram_we_n;
    logic [15:0] o_sram_wdata;
    logic [15:0] i_sram_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    sram_arbiter #(.NUM_REQ(2)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_req        (i_req),
        .i_we_n       (i_we_n),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_ack        (o_ack),
        .o_rdata      (o_rdata),
        .o_busy       (o_busy),
        .o_sram_addr  (o_sram_addr),
        .o_sram_we_n  (o_sram_we_n),
        .o_sram_wdata (o_sram_wdata),
        .i_sram_rdata (i_sram_rdata)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // SRAM model: 256 words decoded from the low address byte, reloaded on reset.
    logic [15:0] mem [256];
    always @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int k = 0; k < 256; k++) mem[k] <= 16'h0000;
            mem[8'h05] <= 16'hBEEF;
            mem[8'h40] <= 16'h4040;
        end else if (!o_sram_we_n) begin
            mem[o_sram_addr[7:0]] <= o_sram_wdata;
        end
    end
    assign i_sram_rdata = mem[o_sram_addr[7:0]];

    typedef struct {
        int          c;
        logic        we_n;
        logic [19:0] addr;
        logic [15:0] wdata;
        int          exp_lat;
        logic [1:0]  exp_ack;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input int c, input logic we_n, input logic [19:0] addr,
                         input logic [15:0] wdata);
        i_req[c]            = 1'b1;
        i_we_n[c]           = we_n;
        i_addr[c*20 +: 20]  = addr;
        i_wdata[c*16 +: 16] = wdata;
    endtask

    task automatic wait_ack(input string name, output logic [1:0] a);
        a = 2'b00;
        for (int n = 0; n < 12; n++) begin
            tick();
            if (o_ack != 2'b00) begin
                a = o_ack;
                break;
            end
        end
        if (a == 2'b00) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (o_busy && n < 12) begin
            tick();
            n++;
        end
        chk({name, "_idle"}, {31'd0, o_busy}, 32'd0);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        drive(v.c, v.we_n, v.addr, v.wdata);
        tick();
        chk("t1_addr", o_sram_addr, v.addr);
        chk("t1_we_n", o_sram_we_n, v.we_n);
        chk("t1_wdata", o_sram_wdata, v.we_n ? 16'h0000 : v.wdata);
        chk("t1_busy", o_busy, 1'b1);
        lat = 1;
        while (o_ack == 2'b00 && lat < 8) begin
            tick();
            lat++;
            if (v.we_n && lat == 2) chk("rd_addr_hold", o_sram_addr, v.addr);
        end
        chk("latency", lat, v.exp_lat);
        chk("ack", o_ack, v.exp_ack);
        chk("rdata", o_rdata, v.exp_rdata);
        i_req[v.c] = 1'b0;
        tick();
        chk("after_ack", o_ack, 2'b00);
        chk("after_busy", o_busy, 1'b0);
    endtask

    logic [1:0] a;
    int c0cnt;
    logic c1_seen;
    logic ack_seen;

    initial begin
        i_rst_n = 1'b0;
        i_req   = '0;
        i_we_n  = '1;
        i_addr  = '0;
        i_wdata = '0;

        //        c  we_n  addr          wdata     lat ack    rdata
        vecs[0] = '{0, 1'b0, 20'd32000,  16'h1234, 2, 2'b01, 16'h0000};
        vecs[1] = '{1, 1'b1, 20'd32005,  16'h0000, 3, 2'b10, 16'hBEEF};
        vecs[2] = '{1, 1'b1, 20'd32000,  16'h0000, 3, 2'b10, 16'h1234};
        vecs[3] = '{1, 1'b0, 20'd351999, 16'hA5A5, 2, 2'b10, 16'h1234};
        vecs[4] = '{0, 1'b1, 20'd351999, 16'h0000, 3, 2'b01, 16'hA5A5};
        vecs[5] = '{0, 1'b0, 20'd32005,  16'h0F0F, 2, 2'b01, 16'hA5A5};
        vecs[6] = '{1, 1'b1, 20'd32005,  16'h0000, 3, 2'b10, 16'h0F0F};

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_ack", o_ack, 2'b00);
        chk("rst_rdata", o_rdata, 16'h0000);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_addr", o_sram_addr, 20'd0);
        chk("rst_we_n", o_sram_we_n, 1'b1);
        chk("rst_wdata", o_sram_wdata, 16'h0000);
        i_rst_n = 1'b1;
        tick();

        for (int v = 0; v < 7; v++) run_vec(vecs[v]);

        // Contention from reset: client 0 first, then client 1, pointer back at 0.
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        tick();
        for (int r = 0; r < 2; r++) begin
            drive(0, 1'b1, 20'd32005, 16'h0000);
            drive(1, 1'b1, 20'd40000, 16'h0000);
            wait_ack("cont_a", a);
            chk("cont_first", a, 2'b01);
            chk("cont_first_rdata", o_rdata, 16'hBEEF);
            i_req[0] = 1'b0;
            wait_ack("cont_b", a);
            chk("cont_second", a, 2'b10);
            chk("cont_second_rdata", o_rdata, 16'h4040);
            i_req[1] = 1'b0;
        end
        wait_idle("cont");

        // Fairness: client 0 holds its request; client 1 gets in after one client-0 write.
        drive(0, 1'b0, 20'd32001, 16'h1111);
        tick();
        drive(1, 1'b0, 20'd32002, 16'h2222);
        c0cnt   = 0;
        c1_seen = 1'b0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (o_ack[0]) c0cnt++;
            if (o_ack[1]) begin
                c1_seen = 1'b1;
                break;
            end
        end
        chk("fair_c1_acked", c1_seen, 1'b1);
        chk("fair_c0_before_c1", c0cnt, 1);
        i_req = 2'b00;
        wait_idle("fair");
        tick();
        run_vec('{1, 1'b1, 20'd32002, 16'h0000, 3, 2'b10, 16'h2222});
        run_vec('{0, 1'b1, 20'd32001, 16'h0000, 3, 2'b01, 16'h1111});

        // Inputs changed and request dropped right after the latch.
        drive(0, 1'b1, 20'd40000, 16'h0000);
        tick();
        chk("drop_t1_addr", o_sram_addr, 20'd40000);
        i_addr[19:0] = 20'd50000;
        i_req[0]     = 1'b0;
        tick();
        chk("drop_t2_addr", o_sram_addr, 20'd40000);
        chk("drop_t2_ack", o_ack, 2'b00);
        tick();
        chk("drop_t3_ack", o_ack, 2'b01);
        chk("drop_t3_rdata", o_rdata, 16'h4040);
        tick();
        chk("drop_no_rearb", o_busy, 1'b0);

        // Reset during the write cycle.
        drive(0, 1'b0, 20'd32010, 16'h5555);
        tick();
        chk("rstw_we_low", o_sram_we_n, 1'b0);
        #2;
        i_rst_n  = 1'b0;
        i_req[0] = 1'b0;
        #1;
        chk("rstw_we_async", o_sram_we_n, 1'b1);
        chk("rstw_busy", o_busy, 1'b0);
        chk("rstw_addr", o_sram_addr, 20'd0);
        tick();
        i_rst_n  = 1'b1;
        ack_seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            tick();
            if (o_ack != 2'b00) ack_seen = 1'b1;
        end
        chk("rstw_no_ack", ack_seen, 1'b0);
        chk("rstw_rdata", o_rdata, 16'h0000);
        chk("rstw_idle", o_busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
